accumulator_sched: RTL and testbench

- Round-robin scheduler that shares one nibble-serial accumulator (start / data_in[3:0] / data_out[3:0] / data_out_valid / result_complete / ready) between NUM_REQ requesters.
- The granted requester pushes a job of word-wide operands into an internal buffer.
- The controller then streams the operands to the accumulator LSB-nibble-first, collects the serial result, and returns it word-wide to the same requester.
- Sits between requester-side MAC logic and the accumulator instance.

---
 rtl/accumulator_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 27 ++
 rtl/accumulator_sched.sv | 184 ++++++++++++++++++
 tb/tb_accumulator_sched.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared types and helpers for the accumulator scheduler
package accumulator_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RDY,
        SEND,
        COLLECT,
        RESP
    } sched_state_t;

    // Number of nibbles in a word of the given width
    function automatic int nibbles(input int bit_width);
        return bit_width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, searches upward from ptr
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    // First requester at or above ptr wins, wrapping past N-1 back to 0
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accumulator_sched.sv
// rtl/accumulator_sched.sv - round-robin job scheduler for a shared nibble-serial accumulator
module accumulator_sched
    import accumulator_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_REQ   = 2,
    parameter int MAX_OPS   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic [NUM_REQ-1:0]           op_valid,
    input  logic [NUM_REQ-1:0]           op_last,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] op_data,
    output logic                         op_ready,
    output logic [NUM_REQ-1:0]           res_valid,
    output logic [BIT_WIDTH-1:0]         res_data,
    output logic                         res_err,
    input  logic [NUM_REQ-1:0]           res_ready,
    output logic                         acc_start,
    output logic [3:0]                   acc_data_in,
    input  logic [3:0]                   acc_data_out,
    input  logic                         acc_data_out_valid,
    input  logic                         acc_result_complete,
    input  logic                         acc_ready
);

    localparam int NIB       = nibbles(BIT_WIDTH);
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W     = $clog2(MAX_OPS + 1);
    localparam int OP_W      = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
    localparam int NIB_IDX_W = $clog2(NIB);
    localparam int RCNT_W    = $clog2(NIB + 1);

    sched_state_t           state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       gidx;
    logic [PTR_W-1:0]       arb_idx;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [BIT_WIDTH-1:0]   op_buf [MAX_OPS];
    logic [CNT_W-1:0]       cnt;
    logic [OP_W-1:0]        snd_op;
    logic [NIB_IDX_W-1:0]   snd_nib;
    logic                   snd_done;
    logic                   snd_last;
    logic [BIT_WIDTH-1:0]   snd_word;
    logic [BIT_WIDTH-1:0]   sel_data;
    logic                   op_accept;
    logic [BIT_WIDTH-1:0]   res_acc;
    logic [BIT_WIDTH-1:0]   res_acc_next;
    logic [RCNT_W-1:0]      rcnt;
    logic [RCNT_W-1:0]      rcnt_next;

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_gnt)
    );

    // One-hot arbiter grant to an index for operand/result steering
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) arb_idx = PTR_W'(i);
        end
    end

    assign sel_data  = op_data[int'(gidx)*BIT_WIDTH +: BIT_WIDTH];
    assign op_accept = (state == LOAD) && op_ready && op_valid[gidx];
    assign snd_word  = op_buf[snd_op];
    assign snd_last  = (snd_nib == NIB_IDX_W'(NIB - 1)) && (CNT_W'(snd_op) == cnt - CNT_W'(1));

    // Result nibble shift-in: only while sending or collecting, surplus nibbles dropped
    always_comb begin
        res_acc_next = res_acc;
        rcnt_next    = rcnt;
        if ((state == SEND || state == COLLECT) && acc_data_out_valid && rcnt < RCNT_W'(NIB)) begin
            res_acc_next[int'(rcnt)*NIBBLE_W +: NIBBLE_W] = acc_data_out;
            rcnt_next = rcnt + RCNT_W'(1);
        end
    end

    // Operand buffer holds job data only, so it needs no reset
    always_ff @(posedge clk) begin
        if (op_accept) op_buf[OP_W'(cnt)] <= sel_data;
    end

    // Job sequencing: grant, load, wait for accumulator, stream, collect, respond
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            gidx        <= '0;
            ptr         <= '0;
            cnt         <= '0;
            op_ready    <= 1'b0;
            res_valid   <= '0;
            res_data    <= '0;
            res_err     <= 1'b0;
            acc_start   <= 1'b0;
            acc_data_in <= '0;
            snd_op      <= '0;
            snd_nib     <= '0;
            snd_done    <= 1'b0;
            res_acc     <= '0;
            rcnt        <= '0;
        end else begin
            res_acc <= res_acc_next;
            rcnt    <= rcnt_next;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= arb_gnt;
                        gidx     <= arb_idx;
                        op_ready <= 1'b1;
                        cnt      <= '0;
                        res_acc  <= '0;
                        rcnt     <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (op_accept) begin
                        cnt <= cnt + CNT_W'(1);
                        if (op_last[gidx] || cnt == CNT_W'(MAX_OPS - 1)) begin
                            op_ready <= 1'b0;
                            state    <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    // First nibble goes out with start on the very first SEND cycle
                    if (acc_ready) begin
                        acc_start   <= 1'b1;
                        acc_data_in <= op_buf[0][NIBBLE_W-1:0];
                        snd_op      <= '0;
                        snd_nib     <= NIB_IDX_W'(1);
                        snd_done    <= 1'b0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (snd_done) begin
                        acc_start   <= 1'b0;
                        acc_data_in <= '0;
                        state       <= COLLECT;
                    end else begin
                        acc_data_in <= snd_word[int'(snd_nib)*NIBBLE_W +: NIBBLE_W];
                        acc_start   <= snd_last;
                        snd_done    <= snd_last;
                        if (snd_nib == NIB_IDX_W'(NIB - 1)) begin
                            snd_nib <= '0;
                            snd_op  <= snd_op + OP_W'(1);
                        end else begin
                            snd_nib <= snd_nib + NIB_IDX_W'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (acc_result_complete) begin
                        res_valid <= gnt;
                        res_data  <= res_acc_next;
                        res_err   <= (rcnt_next != RCNT_W'(NIB));
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (|(res_ready & gnt)) begin
                        res_valid <= '0;
                        gnt       <= '0;
                        ptr       <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
                        cnt       <= '0;
                        rcnt      <= '0;
                        res_acc   <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_sched.sv
// tb/tb_accumulator_sched.sv - self-checking bench for accumulator_sched with accumulator model
module tb_accumulator_sched;

    localparam int BW  = 16;
    localparam int NR  = 2;
    localparam int MO  = 8;
    localparam int NIB = BW / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    op_valid = '0;
    logic [NR-1:0]    op_last = '0;
    logic [NR*BW-1:0] op_data = '0;
    logic             op_ready;
    logic [NR-1:0]    res_valid;
    logic [BW-1:0]    res_data;
    logic             res_err;
    logic [NR-1:0]    res_ready = '0;
    logic             acc_start;
    logic [3:0]       acc_data_in;
    logic [3:0]       acc_data_out = '0;
    logic             acc_data_out_valid = 1'b0;
    logic             acc_result_complete = 1'b0;
    logic             acc_ready;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] job_q[$];

    accumulator_sched #(.BIT_WIDTH(BW), .NUM_REQ(NR), .MAX_OPS(MO)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req                 (req),
        .gnt                 (gnt),
        .op_valid            (op_valid),
        .op_last             (op_last),
        .op_data             (op_data),
        .op_ready            (op_ready),
        .res_valid           (res_valid),
        .res_data            (res_data),
        .res_err             (res_err),
        .res_ready           (res_ready),
        .acc_start           (acc_start),
        .acc_data_in         (acc_data_in),
        .acc_data_out        (acc_data_out),
        .acc_data_out_valid  (acc_data_out_valid),
        .acc_result_complete (acc_result_complete),
        .acc_ready           (acc_ready)
    );

    always #5 clk = ~clk;

    // Accumulator model: start opens a job, next start closes it, then the sum comes back nibble-serial
    int            m_state = 0;
    int            m_pos = 0;
    int            m_idx = 0;
    logic [BW-1:0] m_cur = '0;
    logic [BW-1:0] m_sum = '0;
    bit            m_stall = 1'b0;
    bit            m_abort = 1'b0;
    bit            m_short = 1'b0;

    assign acc_ready = (m_state == 0) && !m_stall;

    always @(posedge clk) begin : acc_model
        logic [BW-1:0] cur;
        logic [BW-1:0] sum;
        int pos;
        int n_out;
        acc_data_out_valid  <= 1'b0;
        acc_result_complete <= 1'b0;
        acc_data_out        <= 4'h0;
        n_out = m_short ? NIB - 1 : NIB;
        if (m_abort) begin
            m_state <= 0;
        end else if ((m_state == 0 && acc_start) || m_state == 1) begin
            cur = (m_state == 0) ? '0 : m_cur;
            sum = (m_state == 0) ? '0 : m_sum;
            pos = (m_state == 0) ? 0 : m_pos;
            cur[pos*4 +: 4] = acc_data_in;
            pos = pos + 1;
            if (pos == NIB) begin
                sum = sum + cur;
                cur = '0;
                pos = 0;
            end
            m_cur <= cur;
            m_sum <= sum;
            m_pos <= pos;
            if (m_state == 1 && acc_start) begin
                m_state <= 2;
                m_idx   <= 0;
            end else begin
                m_state <= 1;
            end
        end else if (m_state == 2) begin
            acc_data_out_valid <= 1'b1;
            acc_data_out       <= m_sum[m_idx*4 +: 4];
            if (m_idx == n_out - 1) begin
                acc_result_complete <= 1'b1;
                m_state             <= 0;
            end
            m_idx <= m_idx + 1;
        end
    end

    function automatic logic [NR-1:0] oh(input int r);
        logic [NR-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic grant_wait(input int r, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ($countones(gnt) > 1) begin
                errors++;
                $display("FAIL gnt_onehot gnt=%b", gnt);
            end
            if (gnt != '0) begin
                checks++;
                if (gnt !== oh(r)) begin
                    errors++;
                    $display("FAIL grant_owner gnt=%b expected=%b", gnt, oh(r));
                end
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout gnt=%b expected=%b", gnt, oh(r));
        end
    endtask

    task automatic push_ops(input int r, input bit last_at_end, output int accepted);
        int c;
        accepted = 0;
        for (int i = 0; i < job_q.size(); i++) begin
            if (accepted == MO) begin
                op_valid[r] = 1'b1;
                op_data[r*BW +: BW] = job_q[i];
                op_last[r] = last_at_end && (i == job_q.size() - 1);
                checks++;
                if (op_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL op_ready_full got=%b expected=0", op_ready);
                end
                break;
            end
            if ($urandom_range(0, 3) == 0) begin
                op_valid[r] = 1'b0;
                @(negedge clk);
            end
            op_valid[r] = 1'b1;
            op_data[r*BW +: BW] = job_q[i];
            op_last[r] = last_at_end && (i == job_q.size() - 1);
            c = 0;
            while (op_ready !== 1'b1 && c < 20) begin
                @(negedge clk);
                c++;
            end
            if (c == 20) begin
                checks++;
                errors++;
                $display("FAIL op_ready_timeout got=%b expected=1", op_ready);
                break;
            end
            @(negedge clk);
            accepted++;
        end
    endtask

    task automatic check_send(input int n);
        int c;
        logic [BW-1:0] w;
        logic [3:0] exp_d;
        logic exp_s;
        c = 0;
        while (acc_start !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (c == 60) begin
            checks++;
            errors++;
            $display("FAIL send_start_timeout got=%b expected=1", acc_start);
            return;
        end
        for (int k = 0; k < n * NIB; k++) begin
            w     = job_q[k / NIB];
            exp_d = w[(k % NIB)*4 +: 4];
            exp_s = (k == 0) || (k == n * NIB - 1);
            checks++;
            if (acc_start !== exp_s || acc_data_in !== exp_d) begin
                errors++;
                $display("FAIL send_nibble k=%0d got start=%b data=%h expected start=%b data=%h", k, acc_start, acc_data_in, exp_s, exp_d);
            end
            @(negedge clk);
        end
        checks++;
        if (acc_start !== 1'b0 || acc_data_in !== 4'h0) begin
            errors++;
            $display("FAIL send_tail got start=%b data=%h expected 0/0", acc_start, acc_data_in);
        end
    endtask

    task automatic check_result(input int r, input logic [BW-1:0] exp, input bit exp_err, input int hold);
        int c;
        c = 0;
        while (res_valid === '0 && c < 80) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (res_valid !== oh(r)) begin
            errors++;
            $display("FAIL res_valid got=%b expected=%b", res_valid, oh(r));
        end
        checks++;
        if (res_data !== exp) begin
            errors++;
            $display("FAIL res_data got=%h expected=%h", res_data, exp);
        end
        checks++;
        if (res_err !== exp_err) begin
            errors++;
            $display("FAIL res_err got=%b expected=%b", res_err, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== oh(r) || res_data !== exp || gnt !== oh(r)) begin
                errors++;
                $display("FAIL res_hold cyc=%0d got valid=%b data=%h gnt=%b expected valid=%b data=%h gnt=%b", h, res_valid, res_data, gnt, oh(r), exp, oh(r));
            end
        end
        res_ready[r] = 1'b1;
        @(negedge clk);
        res_ready[r] = 1'b0;
        checks++;
        if (res_valid !== '0 || gnt !== '0) begin
            errors++;
            $display("FAIL res_release got valid=%b gnt=%b expected 0/0", res_valid, gnt);
        end
    endtask

    task automatic serve(input int r, input bit last_at_end, input int stall, input bit short_m, input int hold);
        int acc_n;
        int exp_n;
        logic [BW-1:0] exp_sum;
        m_stall = (stall > 0);
        m_short = short_m;
        push_ops(r, last_at_end, acc_n);
        exp_n = (job_q.size() > MO) ? MO : job_q.size();
        checks++;
        if (acc_n != exp_n) begin
            errors++;
            $display("FAIL op_count got=%0d expected=%0d", acc_n, exp_n);
        end
        for (int c = 0; c < stall; c++) begin
            checks++;
            if (acc_start !== 1'b0 || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_quiet got start=%b op_ready=%b expected 0/0", acc_start, op_ready);
            end
            @(negedge clk);
        end
        op_valid[r] = 1'b0;
        op_last[r]  = 1'b0;
        if (stall > 0) begin
            m_abort = 1'b1;
            m_stall = 1'b0;
            @(negedge clk);
            m_abort = 1'b0;
        end
        check_send(acc_n);
        exp_sum = '0;
        for (int i = 0; i < acc_n; i++) exp_sum = exp_sum + job_q[i];
        if (short_m) exp_sum = exp_sum & ({BW{1'b1}} >> 4);
        check_result(r, exp_sum, short_m, hold);
        m_short = 1'b0;
    endtask

    task automatic run_job(input int r, input int stall, input bit short_m, input int hold);
        bit ok;
        req[r] = 1'b1;
        grant_wait(r, ok);
        req[r] = 1'b0;
        if (ok) serve(r, 1'b1, stall, short_m, hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, op_ready, res_valid, res_data, res_err, acc_start, acc_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b op_ready=%b res_valid=%b res_data=%h res_err=%b start=%b data=%h expected all 0", gnt, op_ready, res_valid, res_data, res_err, acc_start, acc_data_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got gnt=%b op_ready=%b expected 0/0", gnt, op_ready);
        end
    endtask

    task automatic test_basic();
        job_q = {16'd10, 16'd20, 16'd30};
        run_job(0, 0, 1'b0, 0);
    endtask

    task automatic test_single();
        job_q = {16'd42};
        run_job(1, 0, 1'b0, 0);
    endtask

    task automatic test_overflow();
        job_q = {16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h6000};
        run_job(0, 0, 1'b0, 0);
    endtask

    task automatic test_full();
        job_q = {};
        for (int i = 0; i < MO + 1; i++) job_q.push_back(BW'($urandom));
        run_job(1, 5, 1'b0, 0);
    endtask

    task automatic test_round_robin();
        bit ok;
        job_q = {16'd1, 16'd2};
        req = 2'b11;
        grant_wait(0, ok);
        if (ok) serve(0, 1'b1, 0, 1'b0, 0);
        job_q = {16'd3};
        grant_wait(1, ok);
        if (ok) serve(1, 1'b1, 0, 1'b0, 0);
        job_q = {16'hFFFF, 16'd2};
        grant_wait(0, ok);
        if (ok) serve(0, 1'b1, 0, 1'b0, 0);
        req = 2'b00;
    endtask

    task automatic test_hold();
        bit ok;
        job_q = {16'h1234, 16'h0101, 16'h00FF};
        req = 2'b01;
        grant_wait(0, ok);
        req = 2'b10;
        if (ok) serve(0, 1'b1, 0, 1'b0, 20);
        job_q = {16'h7777};
        grant_wait(1, ok);
        req = 2'b00;
        if (ok) serve(1, 1'b1, 0, 1'b0, 0);
    endtask

    task automatic test_err();
        job_q = {16'hABCD, 16'h1111};
        run_job(0, 0, 1'b1, 2);
    endtask

    task automatic test_random();
        int r;
        int n;
        for (int j = 0; j < 6; j++) begin
            r = $urandom_range(0, NR - 1);
            n = $urandom_range(1, MO);
            job_q = {};
            for (int i = 0; i < n; i++) job_q.push_back(BW'($urandom));
            run_job(r, ($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0, 1'b0, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int acc_n;
        int c;
        job_q = {};
        for (int i = 0; i < 3; i++) job_q.push_back(BW'($urandom));
        req[1] = 1'b1;
        grant_wait(1, ok);
        req[1] = 1'b0;
        if (ok) push_ops(1, 1'b1, acc_n);
        op_valid = '0;
        op_last  = '0;
        c = 0;
        while (acc_start !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, op_ready, res_valid, res_data, res_err, acc_start, acc_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_mid_send got gnt=%b op_ready=%b res_valid=%b res_data=%h start=%b data=%h expected all 0", gnt, op_ready, res_valid, res_data, acc_start, acc_data_in);
        end
        rst_n = 1'b1;
        job_q = {16'h0F0F, 16'h1234};
        req = 2'b11;
        grant_wait(0, ok);
        req = 2'b00;
        if (ok) serve(0, 1'b1, 15, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_overflow();
        test_full();
        test_round_robin();
        test_hold();
        test_err();
        test_random();
        test_reset_mid_send();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
